// File: rtl/gray_pkg.sv
// Purpose: shared Gray-code helpers for the gray counter slice.
// Latency: n/a (functions and constants only).
// Backpressure: n/a.
// Contents:
//   MAX_W      widest counter supported by the helpers (16)
//   MAX_VAL()  all-ones value for a given width
//   bin2gray() / gray2bin()  width-generic conversions on zero-extended data
package gray_pkg;

  localparam int MAX_W = 16;

  // All-ones value for a counter of width w, e.g. MAX_VAL(4) = 15.
  function automatic int unsigned MAX_VAL(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Callers zero-extend their WIDTH-bit value to MAX_W bits. The zero upper
  // bits leave the low WIDTH bits of the result correct for any width.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR running from the MSB down: b[i] = g[MSB] ^ ... ^ g[i].
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Purpose: combinational Gray-to-binary converter, WIDTH bits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: gray_dat (Gray-coded input), bin_dat (binary equivalent).
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_dat,
  output logic [WIDTH-1:0] bin_dat
);
  import gray_pkg::*;

  assign bin_dat = WIDTH'(gray2bin(MAX_W'(gray_dat)));

endmodule

// File: rtl/gray_counter_param.sv
// Purpose: parametrised up/down Gray counter with load and a wrap or saturate end mode.
// Latency: 1 cycle from any sampled input to q_gray/q_bin/term.
// Backpressure: none; a step is taken on every enabled edge.
// Ports: clk, reset_n (async, active low), en, up_dn, load, load_gray[WIDTH] in;
//        q_gray[WIDTH], q_bin[WIDTH], term (one-cycle end-of-range pulse) out.
module gray_counter_param #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] q_gray,
  output logic [WIDTH-1:0] q_bin,
  output logic             term
);
  import gray_pkg::*;

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL(WIDTH));

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] next_b;
  logic [WIDTH-1:0] next_gray;
  logic             next_term;

  gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
    .gray_dat (load_gray),
    .bin_dat  (load_bin)
  );

  // Priority: load, then count, otherwise hold. q_gray is registered
  // alongside b, so it never glitches and can safely feed a CDC synchroniser.
  always_comb begin
    next_b    = b;
    next_gray = q_gray;
    next_term = 1'b0;
    if (load) begin
      next_b    = load_bin;
      next_gray = load_gray;
    end else if (en) begin
      if (up_dn) begin
        if (b == MAX) begin
          next_term = 1'b1;
          if (!SATURATE) next_b = '0;
        end else begin
          next_b = b + WIDTH'(1);
        end
      end else begin
        if (b == '0) begin
          next_term = 1'b1;
          if (!SATURATE) next_b = MAX;
        end else begin
          next_b = b - WIDTH'(1);
        end
      end
      next_gray = WIDTH'(bin2gray(MAX_W'(next_b)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b      <= '0;
      q_gray <= '0;
      term   <= 1'b0;
    end else begin
      b      <= next_b;
      q_gray <= next_gray;
      term   <= next_term;
    end
  end

  assign q_bin = b;

endmodule

// File: tb/tb_gray_counter_param.sv
module tb_gray_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] lg4;
  logic [1:0] lg2;
  logic [7:0] lg8;

  logic [3:0] g4, b4, g4s, b4s;
  logic [1:0] g2, b2;
  logic [7:0] g8, b8;
  logic       t4, t4s, t2, t8;

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b0)) u_w4 (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_gray(lg4), .q_gray(g4), .q_bin(b4), .term(t4));
  gray_counter_param #(.WIDTH(4), .SATURATE(1'b1)) u_w4s (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_gray(lg4), .q_gray(g4s), .q_bin(b4s), .term(t4s));
  gray_counter_param #(.WIDTH(2), .SATURATE(1'b0)) u_w2 (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_gray(lg2), .q_gray(g2), .q_bin(b2), .term(t2));
  gray_counter_param #(.WIDTH(8), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_gray(lg8), .q_gray(g8), .q_bin(b8), .term(t8));

  localparam int WID [4] = '{4, 4, 2, 8};
  localparam bit SAT [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  int obs_b [4];
  int obs_g [4];
  bit obs_t [4];
  always_comb begin
    obs_b[0] = int'(b4);  obs_g[0] = int'(g4);  obs_t[0] = t4;
    obs_b[1] = int'(b4s); obs_g[1] = int'(g4s); obs_t[1] = t4s;
    obs_b[2] = int'(b2);  obs_g[2] = int'(g2);  obs_t[2] = t2;
    obs_b[3] = int'(b8);  obs_g[3] = int'(g8);  obs_t[3] = t8;
  end

  // Reference model: plain integer position per instance.
  int m [4];
  bit mt [4];
  int pg [4];
  bit stepped [4];

  int tests_run    = 0;
  int tests_failed = 0;

  // Find the binary value whose reflected Gray code equals g (exhaustive search).
  function automatic int decode_gray(input int g, input int w);
    for (int v = 0; v < (1 << w); v++) begin
      if ((v ^ (v >> 1)) == g) return v;
    end
    return -1;
  endfunction

  function automatic int load_val(input int i);
    if (i < 2) return int'(lg4);
    if (i == 2) return int'(lg2);
    return int'(lg8);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m[i] = 0; mt[i] = 1'b0; stepped[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    en = 1'b0; up_dn = 1'b0; load = 1'b0;
    reset_n = 1'b0;
    #5;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive one edge with the given controls (load values come from lg*).
  task automatic tick(input bit e, input bit u, input bit l);
    int maxv;
    int old;
    en = e; up_dn = u; load = l;
    for (int i = 0; i < 4; i++) pg[i] = obs_g[i];
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      maxv = (1 << WID[i]) - 1;
      old = m[i];
      stepped[i] = 1'b0;
      if (l) begin
        m[i] = decode_gray(load_val(i), WID[i]);
        mt[i] = 1'b0;
      end else if (e) begin
        if (u) begin
          if (m[i] == maxv) begin mt[i] = 1'b1; if (!SAT[i]) m[i] = 0; end
          else begin m[i] = m[i] + 1; mt[i] = 1'b0; end
        end else begin
          if (m[i] == 0) begin mt[i] = 1'b1; if (!SAT[i]) m[i] = maxv; end
          else begin m[i] = m[i] - 1; mt[i] = 1'b0; end
        end
        stepped[i] = (m[i] != old);
      end else begin
        mt[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0;
    lg4 = '0; lg2 = '0; lg8 = '0;
    #2;
    reset_n = 1'b0;
    #5;
    for (int i = 0; i < 4; i++) begin
      tests_run += 3;
      if (obs_b[i] !== 0) begin tests_failed++; $display("FAIL reset_bin inst%0d got %0d want 0", i, obs_b[i]); end
      if (obs_g[i] !== 0) begin tests_failed++; $display("FAIL reset_gray inst%0d got %0d want 0", i, obs_g[i]); end
      if (obs_t[i] !== 1'b0) begin tests_failed++; $display("FAIL reset_term inst%0d got %0b want 0", i, obs_t[i]); end
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      tick(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
        tests_run += 3;
        if (obs_b[i] !== m[i]) begin tests_failed++; $display("FAIL up_bin inst%0d step%0d got %0d want %0d", i, k, obs_b[i], m[i]); end
        if (obs_g[i] !== (m[i] ^ (m[i] >> 1))) begin tests_failed++; $display("FAIL up_gray inst%0d step%0d got %0d want %0d", i, k, obs_g[i], m[i] ^ (m[i] >> 1)); end
        if (obs_t[i] !== mt[i]) begin tests_failed++; $display("FAIL up_term inst%0d step%0d got %0b want %0b", i, k, obs_t[i], mt[i]); end
        if (stepped[i]) begin
          tests_run++;
          if ($countones(pg[i] ^ obs_g[i]) != 1) begin tests_failed++; $display("FAIL up_onebit inst%0d step%0d got %0d->%0d want one bit", i, k, pg[i], obs_g[i]); end
        end
      end
      if (k == 16) begin
        tests_run += 2;
        if (b4 !== 4'd0) begin tests_failed++; $display("FAIL up_wrap_bin got %0d want 0", b4); end
        if (t4 !== 1'b1) begin tests_failed++; $display("FAIL up_wrap_term got %0b want 1", t4); end
      end
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    tests_run += 3;
    if (b4 !== 4'd15) begin tests_failed++; $display("FAIL down_wrap_bin got %0d want 15", b4); end
    if (g4 !== 4'b1000) begin tests_failed++; $display("FAIL down_wrap_gray got %b want 1000", g4); end
    if (t4 !== 1'b1) begin tests_failed++; $display("FAIL down_wrap_term got %0b want 1", t4); end
    tests_run += 2;
    if (b4s !== 4'd0 || t4s !== 1'b1) begin tests_failed++; $display("FAIL down_sat_floor got %0d/%0b want 0/1", b4s, t4s); end
    if (b8 !== 8'd255) begin tests_failed++; $display("FAIL down_wrap_w8 got %0d want 255", b8); end
    tick(1'b1, 1'b0, 1'b0);
    tests_run += 2;
    if (b4 !== 4'd14) begin tests_failed++; $display("FAIL down_next_bin got %0d want 14", b4); end
    if (t4 !== 1'b0) begin tests_failed++; $display("FAIL down_next_term got %0b want 0", t4); end
  endtask

  task automatic test_saturate();
    do_reset();
    lg4 = 4'b1000; lg2 = 2'b10; lg8 = 8'b1000_0000;
    tick(1'b0, 1'b0, 1'b1);
    tests_run++;
    if (b4s !== 4'd15) begin tests_failed++; $display("FAIL sat_load got %0d want 15", b4s); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1, 1'b0);
      tests_run += 3;
      if (b4s !== 4'd15) begin tests_failed++; $display("FAIL sat_hold step%0d got %0d want 15", k, b4s); end
      if (t4s !== 1'b1) begin tests_failed++; $display("FAIL sat_term step%0d got %0b want 1", k, t4s); end
      if (obs_b[0] !== m[0] || obs_t[0] !== mt[0]) begin tests_failed++; $display("FAIL sat_wrap_inst0 step%0d got %0d/%0b want %0d/%0b", k, obs_b[0], obs_t[0], m[0], mt[0]); end
    end
    tick(1'b1, 1'b0, 1'b0);
    tests_run += 2;
    if (b4s !== 4'd14) begin tests_failed++; $display("FAIL sat_reverse_bin got %0d want 14", b4s); end
    if (t4s !== 1'b0) begin tests_failed++; $display("FAIL sat_reverse_term got %0b want 0", t4s); end
  endtask

  task automatic test_load_priority();
    do_reset();
    tick(1'b1, 1'b1, 1'b0);
    lg4 = 4'b0110; lg2 = 2'b01; lg8 = 8'b0000_0110;
    tick(1'b1, 1'b1, 1'b1);
    tests_run += 4;
    if (g4 !== 4'b0110) begin tests_failed++; $display("FAIL load_gray got %b want 0110", g4); end
    if (b4 !== 4'd4) begin tests_failed++; $display("FAIL load_bin got %0d want 4", b4); end
    if (t4 !== 1'b0) begin tests_failed++; $display("FAIL load_term got %0b want 0", t4); end
    if (obs_b[3] !== m[3]) begin tests_failed++; $display("FAIL load_w8 got %0d want %0d", obs_b[3], m[3]); end
    tick(1'b1, 1'b1, 1'b0);
    tests_run += 2;
    if (b4 !== 4'd5) begin tests_failed++; $display("FAIL load_next_bin got %0d want 5", b4); end
    if (g4 !== 4'b0111) begin tests_failed++; $display("FAIL load_next_gray got %b want 0111", g4); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 9; k++) tick(1'b1, 1'b1, 1'b0);
    tests_run++;
    if (b4 !== 4'd9) begin tests_failed++; $display("FAIL async_pre got %0d want 9", b4); end
    #1;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (obs_b[i] !== 0 || obs_g[i] !== 0 || obs_t[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL async_clear inst%0d got %0d/%0d/%0b want 0/0/0", i, obs_b[i], obs_g[i], obs_t[i]);
      end
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    tests_run += 2;
    if (b4 !== 4'd1) begin tests_failed++; $display("FAIL async_resume got %0d want 1", b4); end
    if (obs_b[3] !== m[3]) begin tests_failed++; $display("FAIL async_resume_w8 got %0d want %0d", obs_b[3], m[3]); end
  endtask

  task automatic test_width_sweep();
    int pulses2;
    int pulses8;
    int bad;
    pulses2 = 0; pulses8 = 0; bad = 0;
    do_reset();
    for (int k = 1; k <= 257; k++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (t2) pulses2++;
      if (t8) pulses8++;
      for (int i = 2; i < 4; i++) begin
        if (obs_g[i] !== (obs_b[i] ^ (obs_b[i] >> 1))) bad++;
        if (obs_b[i] !== m[i] || obs_t[i] !== mt[i]) bad++;
        if ($countones(pg[i] ^ obs_g[i]) != 1) bad++;
      end
    end
    tests_run += 3;
    if (pulses2 != 64) begin tests_failed++; $display("FAIL sweep_pulses_w2 got %0d want 64", pulses2); end
    if (pulses8 != 1) begin tests_failed++; $display("FAIL sweep_pulses_w8 got %0d want 1", pulses8); end
    if (bad != 0) begin tests_failed++; $display("FAIL sweep_cycle_checks got %0d bad want 0", bad); end
  endtask

  task automatic test_random();
    bit e, u, l;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      e = ($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 11) == 0);
      lg4 = 4'($urandom); lg2 = 2'($urandom); lg8 = 8'($urandom);
      tick(e, u, l);
      for (int i = 0; i < 4; i++) begin
        tests_run += 3;
        if (obs_b[i] !== m[i]) begin tests_failed++; $display("FAIL rand_bin inst%0d cyc%0d got %0d want %0d", i, k, obs_b[i], m[i]); end
        if (obs_g[i] !== (m[i] ^ (m[i] >> 1))) begin tests_failed++; $display("FAIL rand_gray inst%0d cyc%0d got %0d want %0d", i, k, obs_g[i], m[i] ^ (m[i] >> 1)); end
        if (obs_t[i] !== mt[i]) begin tests_failed++; $display("FAIL rand_term inst%0d cyc%0d got %0b want %0b", i, k, obs_t[i], mt[i]); end
        if (stepped[i]) begin
          tests_run++;
          if ($countones(pg[i] ^ obs_g[i]) != 1) begin tests_failed++; $display("FAIL rand_onebit inst%0d cyc%0d got %0d->%0d", i, k, pg[i], obs_g[i]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load_priority();
    test_async_reset();
    test_width_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
